// File: rtl/adc_spi_sampler_if.sv
// adc_spi_sampler_if: register-side strobes, config words and read data of the ADC sampler
interface adc_spi_sampler_if;
  logic [31:0] cfg_clk_div;
  logic [31:0] cfg_sample;
  logic        cmd_wenable;
  logic [31:0] cmd_wdata;
  logic        status_rrequest;
  logic [31:0] status_rdata;
  logic        fifo_rrequest;
  logic [31:0] fifo_rdata;
  modport master (
    output cfg_clk_div, cfg_sample, cmd_wenable, cmd_wdata, status_rrequest, fifo_rrequest,
    input  status_rdata, fifo_rdata
  );
  modport slave (
    input  cfg_clk_div, cfg_sample, cmd_wenable, cmd_wdata, status_rrequest, fifo_rrequest,
    output status_rdata, fifo_rdata
  );
endinterface

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: mode-0 SPI conversion engine with result FIFO and start/stop/flush commands.
// Defining ADC_SAMPLER_IRQ_EN adds a registered irq output (half-full or overflow).
module adc_spi_sampler #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int CHANNEL_BITS = 3
) (
  input  logic clk,
  input  logic rstnn,
  adc_spi_sampler_if.slave bus,
  output logic adc_cs_n,
  output logic adc_sclk,
  output logic adc_mosi,
  input  logic adc_miso
`ifdef ADC_SAMPLER_IRQ_EN
  ,
  output logic irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d, div_q, div_d, gap_q, gap_d, tx_q, tx_d;
  logic [4:0]              edges_q, edges_d, ch5;
  logic [CHANNEL_BITS-1:0] chan_q, chan_d;
  logic [SAMPLE_WIDTH-1:0] rx_q, rx_d;
  logic                    cont_q, cont_d, stop_q, stop_d, sclk_q, sclk_d, push_q, push_d, go;
  logic [AW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]           fill_q, fill_d;
  logic                    ovf_q, ovf_d;
  logic                    busy, start, stop_now, flush, half_done, empty, full, pop, push, ovf_ev;
  logic [SAMPLE_WIDTH-1:0] samp_mem [FIFO_DEPTH];
  logic [CHANNEL_BITS-1:0] chan_mem [FIFO_DEPTH];
  logic                    unused;
  assign unused    = ^{bus.cfg_clk_div[31:16], bus.cfg_sample[15:9], bus.cfg_sample[7:CHANNEL_BITS],
                       bus.cmd_wdata[31:3]};
  assign busy      = state_q != IDLE;
  assign start     = bus.cmd_wenable & bus.cmd_wdata[0] & ~bus.cmd_wdata[1];
  assign stop_now  = stop_q | (bus.cmd_wenable & bus.cmd_wdata[1] & busy);
  assign flush     = bus.cmd_wenable & bus.cmd_wdata[2];
  assign half_done = cnt_q == div_q;
  assign ch5       = 5'(bus.cfg_sample[CHANNEL_BITS-1:0]) << (5 - CHANNEL_BITS);
  assign adc_cs_n  = !(state_q == SETUP || state_q == SHIFT);
  assign adc_sclk  = sclk_q;
  assign adc_mosi  = tx_q[15];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    edges_d = edges_q;
    sclk_d  = sclk_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    push_d  = 1'b0;
    div_d   = div_q;
    gap_d   = gap_q;
    chan_d  = chan_q;
    cont_d  = cont_q;
    go      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        go    = start;
      end
      SETUP: if (half_done) begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: if (half_done) begin
        cnt_d   = '0;
        sclk_d  = !sclk_q;
        edges_d = edges_q + 5'd1;
        rx_d    = sclk_q ? rx_q : SAMPLE_WIDTH'({rx_q, adc_miso});
        tx_d    = sclk_q ? {tx_q[14:0], 1'b0} : tx_q;
        state_d = &edges_q ? HOLD : SHIFT;
        push_d  = &edges_q;
      end
      HOLD: if (half_done) begin
        cnt_d   = '0;
        state_d = (stop_now || !cont_q) ? IDLE : GAP;
        go      = !stop_now && cont_q && gap_q == '0;
      end
      GAP: if (cnt_q == gap_q - 16'd1) begin
        state_d = IDLE;
        go      = !stop_now;
      end
      default: state_d = IDLE;
    endcase
    // every frame re-latches its timing and channel, so cfg writes land on the next frame
    if (go) begin
      state_d = SETUP;
      cnt_d   = '0;
      edges_d = '0;
      sclk_d  = 1'b0;
      div_d   = bus.cfg_clk_div[15:0];
      gap_d   = bus.cfg_sample[31:16];
      chan_d  = bus.cfg_sample[CHANNEL_BITS-1:0];
      cont_d  = bus.cfg_sample[8];
      tx_d    = {2'b00, ch5, 9'b0};
    end
    stop_d = (state_d == IDLE) ? 1'b0 : stop_now;
  end
  assign empty  = fill_q == '0;
  assign full   = fill_q == CW'(FIFO_DEPTH);
  assign pop    = bus.fifo_rrequest & ~empty & ~flush;
  assign push   = push_q & (~full | pop) & ~flush;
  assign ovf_ev = push_q & full & ~pop & ~flush;
  assign fill_d = flush ? '0 : fill_q + CW'(push) - CW'(pop);
  assign wp_d   = flush ? '0 : wp_q + AW'(push);
  assign rp_d   = flush ? '0 : rp_q + AW'(pop);
  assign ovf_d  = ovf_ev | (ovf_q & ~bus.status_rrequest);
  assign bus.status_rdata = {16'h0, 8'(fill_q), 4'h0, ovf_q, full, empty, busy};
  assign bus.fifo_rdata   = empty ? '0 : {1'b1, 5'(chan_mem[rp_q]), 26'(samp_mem[rp_q])};
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edges_q <= '0;
      sclk_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      push_q  <= 1'b0;
      div_q   <= '0;
      gap_q   <= '0;
      chan_q  <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edges_q <= edges_d;
      sclk_q  <= sclk_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      push_q  <= push_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      chan_q  <= chan_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      samp_mem[wp_q] <= rx_q;
      chan_mem[wp_q] <= chan_q;
    end
  end
`ifdef ADC_SAMPLER_IRQ_EN
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) irq <= 1'b0;
    else irq <= (fill_d >= CW'(FIFO_DEPTH / 2)) | ovf_d;
  end
`endif
endmodule
